// File: rtl/fetch_if.sv
// IF-stage bundle: ID-stage control in, instruction-memory handshake, IF/ID pipeline registers out.
interface fetch_if;
  logic        stall;
  logic        jump;
  logic [31:0] addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc_if_id;
  logic [31:0] ir_if_id;

  modport master (
    input  stall, jump, addr, imem_ack, imem_data,
    output imem_req, imem_addr, pc_if_id, ir_if_id
  );

  modport slave (
    output stall, jump, addr, imem_ack, imem_data,
    input  imem_req, imem_addr, pc_if_id, ir_if_id
  );
endinterface

// File: rtl/fetch.sv
// MIPS instruction-fetch stage: req/ack imem fetch, one-entry skid buffer, delay-slot redirect.
// Optional FETCH_PERF_EN adds a wrapping bubble counter port.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_PERF_EN
  output logic [31:0] o_bubble_count,
`endif
  fetch_if.master     bus
);

  logic [31:0] r_pc;
  logic        r_buf_valid;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_ir;
  logic        r_redir_valid;
  logic [31:0] r_redir_addr;
  logic [31:0] r_pc_if_id;
  logic [31:0] r_ir_if_id;

  logic        w_req;
  logic        w_fc;
  logic        w_adv;
  logic        w_load_bubble;
  logic [31:0] w_pc_inc;

  assign w_req         = rst_n & ~r_buf_valid;
  assign w_fc          = w_req & bus.imem_ack;
  assign w_adv         = ~bus.stall;
  assign w_pc_inc      = r_pc + 32'd1;
  assign w_load_bubble = w_adv & ~r_buf_valid & ~w_fc;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.pc_if_id  = r_pc_if_id;
  assign bus.ir_if_id  = r_ir_if_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_buf_valid   <= 1'b0;
      r_buf_pc      <= 32'h0;
      r_buf_ir      <= 32'h0;
      r_redir_valid <= 1'b0;
      r_redir_addr  <= 32'h0;
      r_pc_if_id    <= RESET_PC;
      r_ir_if_id    <= 32'h0;
    end else begin
      if (w_adv) begin
        if (r_buf_valid) begin
          r_pc_if_id  <= r_buf_pc;
          r_ir_if_id  <= r_buf_ir;
          r_buf_valid <= 1'b0;
        end else if (w_fc) begin
          r_pc_if_id <= w_pc_inc;
          r_ir_if_id <= bus.imem_data;
        end else begin
          r_pc_if_id <= r_pc;
          r_ir_if_id <= 32'h0;
        end
      end else if (w_fc) begin
        r_buf_valid <= 1'b1;
        r_buf_pc    <= w_pc_inc;
        r_buf_ir    <= bus.imem_data;
      end

      if (w_fc) begin
        if (r_redir_valid) begin
          r_pc          <= r_redir_addr;
          r_redir_valid <= 1'b0;
        end else begin
          r_pc <= w_pc_inc;
        end
      end

      // Delay slot entering as a real instruction retargets now; a bubble defers to its fetch.
      if (w_adv && bus.jump) begin
        if (w_load_bubble) begin
          r_redir_valid <= 1'b1;
          r_redir_addr  <= bus.addr;
        end else begin
          r_pc <= bus.addr;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= 32'h0;
    end else if (w_load_bubble) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign o_bubble_count = r_bubble_count;
`endif

endmodule
